// File: rtl/shmsk_pipe_if.sv
// Operand/result handshake bundle for the shifter/masker stage.
// out_zero exists only when SHMSK_ZERO_FLAG_EN is defined.
interface shmsk_pipe_if #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_m;
    logic [DATA_W-1:0] in_a;
    logic [SH_W-1:0]   in_s;
    logic [SH_W-1:0]   in_mskl;
    logic [SH_W-1:0]   in_mskr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] out_mask;
`ifdef SHMSK_ZERO_FLAG_EN
    logic              out_zero;
`endif

    modport master (
        output in_valid, in_m, in_a, in_s, in_mskl, in_mskr, out_ready,
        input  in_ready, out_valid, out_r, out_mask
`ifdef SHMSK_ZERO_FLAG_EN
        , input out_zero
`endif
    );

    modport slave (
        input  in_valid, in_m, in_a, in_s, in_mskl, in_mskr, out_ready,
        output in_ready, out_valid, out_r, out_mask
`ifdef SHMSK_ZERO_FLAG_EN
        , output out_zero
`endif
    );
endinterface

// File: rtl/shmsk_pipe.sv
// Two-stage rotate/mask/merge stage (LDB/DPB/selective deposit) with valid/ready.
// Optional macro SHMSK_ZERO_FLAG_EN adds a registered out_zero flag.
module shmsk_pipe #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    shmsk_pipe_if.slave      bus
);
    logic              v1_q, v1_d;
    logic [DATA_W-1:0] rot_q, rot_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] omask_q, omask_d;
`ifdef SHMSK_ZERO_FLAG_EN
    logic              zero_q, zero_d;
`endif

    logic                adv2;
    logic                accept;
    logic [2*DATA_W-1:0] rot_wide;
    logic [DATA_W-1:0]   rot_c;
    logic [DATA_W-1:0]   lmask;
    logic [DATA_W-1:0]   rmask;
    logic [DATA_W-1:0]   merged;

    // Stage 2 can take new data when empty or draining; stage 1 can then move up.
    assign adv2         = ~v2_q | bus.out_ready;
    assign bus.in_ready = ~v1_q | adv2;
    assign accept       = bus.in_valid & bus.in_ready;

    // Upper half of the doubled word shifted left is the left rotation.
    assign rot_wide = {bus.in_m, bus.in_m} << bus.in_s;
    assign rot_c    = rot_wide[2*DATA_W-1:DATA_W];

    for (genvar i = 0; i < DATA_W; i++) begin : g_mask
        assign lmask[i] = (SH_W'(i) <= bus.in_mskl);
        assign rmask[i] = (SH_W'(i) >= bus.in_mskr);
    end

    assign merged = (rot_q & mask_q) | (a_q & ~mask_q);

    always_comb begin
        v1_d    = v1_q;
        rot_d   = rot_q;
        a_d     = a_q;
        mask_d  = mask_q;
        v2_d    = v2_q;
        r_d     = r_q;
        omask_d = omask_q;
`ifdef SHMSK_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        if (bus.in_ready) begin
            v1_d = bus.in_valid;
            if (accept) begin
                rot_d  = rot_c;
                a_d    = bus.in_a;
                mask_d = lmask & rmask;
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            // Output registers only change on a real load, so idle bubbles keep the last result.
            if (v1_q) begin
                r_d     = merged;
                omask_d = mask_q;
`ifdef SHMSK_ZERO_FLAG_EN
                zero_d  = (merged == '0);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q    <= 1'b0;
            rot_q   <= '0;
            a_q     <= '0;
            mask_q  <= '0;
            v2_q    <= 1'b0;
            r_q     <= '0;
            omask_q <= '0;
`ifdef SHMSK_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            v1_q    <= v1_d;
            rot_q   <= rot_d;
            a_q     <= a_d;
            mask_q  <= mask_d;
            v2_q    <= v2_d;
            r_q     <= r_d;
            omask_q <= omask_d;
`ifdef SHMSK_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.out_r     = r_q;
    assign bus.out_mask  = omask_q;
`ifdef SHMSK_ZERO_FLAG_EN
    assign bus.out_zero  = zero_q;
`endif
endmodule

// File: tb/tb_shmsk_pipe.sv
// Directed bench for shmsk_pipe: scoreboard of expected results, monitor pops on output transfers.
module tb_shmsk_pipe;
    localparam int DW = 32;
    localparam int SW = 5;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] mask;
        logic          z;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic          prev_stall;
    logic [DW-1:0] prev_r;
    logic [DW-1:0] prev_mask;

    shmsk_pipe_if #(.DATA_W(DW), .SH_W(SW)) bus ();

    shmsk_pipe #(.DATA_W(DW), .SH_W(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: bit i of the rotation comes from bit (i - s) mod DW.
    function automatic exp_t model(input logic [DW-1:0] m, input logic [DW-1:0] a,
                                   input int s, input int l, input int r);
        exp_t e;
        for (int i = 0; i < DW; i++) begin
            e.mask[i] = (i >= r) && (i <= l);
            e.r[i]    = e.mask[i] ? m[(i + DW - s) % DW] : a[i];
        end
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [DW-1:0] r, input logic [DW-1:0] mask);
        exp_t e;
        e.r = r; e.mask = mask; e.z = (r == '0);
        return e;
    endfunction

    // Scoreboard monitor: compare every output transfer, and hold stability while stalled.
    always @(negedge clk) begin
        if (reset_n && prev_stall && bus.out_valid) begin
            chk("hold_r", bus.out_r, prev_r);
            chk("hold_mask", bus.out_mask, prev_mask);
        end
        if (reset_n && bus.out_valid && bus.out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=%h expected=none", bus.out_r);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_r", bus.out_r, e.r);
                chk("out_mask", bus.out_mask, e.mask);
`ifdef SHMSK_ZERO_FLAG_EN
                chk("out_zero", {31'd0, bus.out_zero}, {31'd0, e.z});
`endif
            end
        end
        prev_stall = reset_n && bus.out_valid && !bus.out_ready;
        prev_r     = bus.out_r;
        prev_mask  = bus.out_mask;
    end

    task automatic drive(input logic [DW-1:0] m, input logic [DW-1:0] a,
                         input int s, input int l, input int r);
        bus.in_valid = 1'b1;
        bus.in_m     = m;
        bus.in_a     = a;
        bus.in_s     = SW'(s);
        bus.in_mskl  = SW'(l);
        bus.in_mskr  = SW'(r);
    endtask

    // Present an op and hold it until accepted; returns at posedge+1 with in_valid still high.
    task automatic send(input logic [DW-1:0] m, input logic [DW-1:0] a,
                        input int s, input int l, input int r, input exp_t e);
        int n;
        drive(m, a, s, l, r);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, bus.in_ready}, 32'd1);
        if (bus.in_ready) sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        exp_t e1, e2, e3;
        checks       = 0;
        errors       = 0;
        prev_stall   = 1'b0;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_m     = '0;
        bus.in_a     = '0;
        bus.in_s     = '0;
        bus.in_mskl  = '0;
        bus.in_mskr  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_r", bus.out_r, 32'd0);
        chk("rst_mask", bus.out_mask, 32'd0);
`ifdef SHMSK_ZERO_FLAG_EN
        chk("rst_zero", {31'd0, bus.out_zero}, 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Field extract with exact latency: presented in cycle c, valid in cycle c+2.
        @(posedge clk); #1;
        drive(32'h000000F0, 32'hFFFFFFF0, 28, 3, 0);
        @(negedge clk);
        chk("fx_ready", {31'd0, bus.in_ready}, 32'd1);
        sb.push_back(mk(32'hFFFFFFFF, 32'h0000000F));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fx_lat1_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("fx_lat2_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;

        send(32'h0000000A, 32'h12345678, 8, 11, 8, mk(32'h12345A78, 32'h00000F00));
        send(32'h13572468, 32'hCAFEBABE, 7, 1, 30, mk(32'hCAFEBABE, 32'h00000000));
        send(32'h80000001, 32'h55AA55AA, 1, 31, 0, mk(32'h00000003, 32'hFFFFFFFF));
        send(32'h0000F000, 32'h00000000, 0, 12, 12, mk(32'h00001000, 32'h00001000));
        send(32'h00000000, 32'h00000000, 9, 20, 4, mk(32'h00000000, 32'h001FFFF0));
        send(32'hFFFFFFFF, 32'h00000001, 3, 0, 5, mk(32'h00000001, 32'h00000000));
        // Back-to-back stream at full throughput.
        for (int k = 0; k < 10; k++) begin
            logic [DW-1:0] m, a;
            int s, l, r;
            m = $urandom; a = $urandom;
            s = $urandom_range(0, 31); l = $urandom_range(0, 31); r = $urandom_range(0, 31);
            send(m, a, s, l, r, model(m, a, s, l, r));
        end
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: third op refused, first result held, then three in a row.
        e1 = model(32'h11111111, 32'h0, 4, 15, 0);
        e2 = model(32'h22222222, 32'hFFFFFFFF, 8, 23, 8);
        e3 = model(32'h33333333, 32'hA5A5A5A5, 16, 31, 16);
        bus.out_ready = 1'b0;
        drive(32'h11111111, 32'h0, 4, 15, 0);
        @(negedge clk);
        chk("bp_acc1", {31'd0, bus.in_ready}, 32'd1);
        sb.push_back(e1);
        @(posedge clk); #1;
        drive(32'h22222222, 32'hFFFFFFFF, 8, 23, 8);
        @(negedge clk);
        chk("bp_acc2", {31'd0, bus.in_ready}, 32'd1);
        sb.push_back(e2);
        @(posedge clk); #1;
        drive(32'h33333333, 32'hA5A5A5A5, 16, 31, 16);
        @(negedge clk);
        chk("bp_full", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_first", bus.out_r, e1.r);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_full2", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_acc3", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_out1", {31'd0, bus.out_valid}, 32'd1);
        sb.push_back(e3);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out2", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_out3", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_done", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-flight with both stages full.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'hDEADBEEF, 32'h0, 0, 31, 0, mk(32'hDEADBEEF, 32'hFFFFFFFF));
        send(32'hBEEFDEAD, 32'h0, 0, 31, 0, mk(32'hBEEFDEAD, 32'hFFFFFFFF));
        bus.in_valid = 1'b0;
        chk("mf_full", {31'd0, bus.in_ready}, 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mf_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mf_r", bus.out_r, 32'd0);
        chk("mf_mask", bus.out_mask, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mf_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("mf_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end

        // Traffic resumes cleanly after reset.
        @(posedge clk); #1;
        send(32'h0000000A, 32'h12345678, 8, 11, 8, mk(32'h12345A78, 32'h00000F00));
        bus.in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shmsk_pipe.md
Name: shmsk_pipe

Overview:
- Shifter/masker datapath stage that consumes the five shift-count bits and the left/right mask bounds produced by the shift/mask control decode.
- Rotates the M-source left by the shift count, builds the field mask, and merges the rotated M with the A-source under that mask. This is the LDB/DPB/SELECTIVE-DEPOSIT result.
- Two-stage registered pipeline with a valid/ready handshake on both sides, feeding the output bus (OB) select.

Parameters:
- DATA_W, 32, datapath width; must equal 2**SH_W.
- SH_W, 5, width of the shift count and mask bounds.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand set valid.
- in_ready  output  1  stage can accept the operand set this cycle.
- in_m  input  DATA_W  M-source operand (value to be rotated).
- in_a  input  DATA_W  A-source operand (background for unmasked bits).
- in_s  input  SH_W  left-rotate count (s4..s0).
- in_mskl  input  SH_W  left mask bound; highest bit set, inclusive.
- in_mskr  input  SH_W  right mask bound; lowest bit set, inclusive.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_r  output  DATA_W  merged result.
- out_mask  output  DATA_W  mask applied, for debug and OB select.

Behaviour:
- Handshake:
  - Transfer occurs on a rising edge when valid and ready are both high.
  - in_ready = ~v1 | (~v2 | out_ready); v1 and v2 are the stage-valid registers.
  - in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
- Stage 1, on accept:
  - rot = in_m rotated left by in_s, mod DATA_W.
  - rmask = ones from bit in_mskr up to DATA_W-1.
  - lmask = ones from bit 0 up to bit in_mskl.
  - Registers: rot, in_a, and mask = lmask & rmask. v1 <= 1.
  - If stage 1 holds data and stage 2 cannot advance, stage 1 holds its contents unchanged.
- Stage 2:
  - Loads from stage 1 when ~v2 | out_ready.
  - out_r <= (rot & mask) | (a & ~mask); out_mask <= mask; v2 <= v1.
- Latency: 2 cycles from accept to out_valid with no backpressure. Sustained throughput is 1 per cycle.
- Bound arithmetic:
  - Unsigned; no wrap correction.
  - in_mskl < in_mskr gives mask = 0 and out_r = a.
  - in_mskl == in_mskr gives a single-bit mask.
  - mskl = 31, mskr = 0 gives all ones and out_r = rot.
  - in_s = 0 means no rotation.
- Backpressure:
  - While out_valid & ~out_ready, out_r and out_mask stay stable.
  - Order is preserved; no result is dropped or duplicated.
  - At most 2 results are in flight; a 3rd is refused (in_ready = 0).
- Simultaneous events: when stage 2 drains and stage 1 loads in the same cycle, both complete, so full throughput is kept.
- Reset, asserted asynchronously at any time including mid-operation:
  - v1 = v2 = 0, out_valid = 0, out_r = 0, out_mask = 0, all stage-1 registers = 0.
  - in_ready = 1 in the first cycle after reset_n rises.
  - In-flight data is discarded.

Optional Feature:
- Macro SHMSK_ZERO_FLAG_EN.
- Defined:
  - Extra output out_zero, 1 bit, registered in stage 2 alongside out_r.
  - out_zero = (out_r == 0), with the same valid/hold rules as out_r. Reset value 0.
- Undefined: port absent, no logic. The rest of the behaviour is identical in both builds.

Test Plan:
- Field extract: in_m=0x000000F0, in_s=28, mskr=0, mskl=3, in_a=0xFFFFFFF0.
  - out_r=0xFFFFFFFF, out_mask=0x0000000F.
  - out_valid exactly 2 cycles after accept.
- Deposit: in_m=0x0000000A, in_s=8, mskr=8, mskl=11, in_a=0x12345678.
  - out_r=0x12345A78, out_mask=0x00000F00.
- Bounds:
  - mskr=30, mskl=1, in_a=0xCAFEBABE gives out_mask=0 and out_r=0xCAFEBABE.
  - mskr=0, mskl=31, in_m=0x80000001, in_s=1 gives out_r=0x00000003.
- Backpressure: issue 3 back-to-back ops with out_ready=0.
  - Two are accepted, then in_ready=0 and out_r holds the first result.
  - Release out_ready: the three results come out in order on 3 consecutive cycles.
- Reset mid-flight: drop reset_n for one cycle while v1 = v2 = 1.
  - out_valid=0 and out_r=0 immediately; in_ready=1 after release; no stale result emerges.
- With SHMSK_ZERO_FLAG_EN: in_m=0, in_a=0 gives out_zero=1; in_a=1 with mask=0 gives out_zero=0.
